tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_tx_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter
// Purpose  : Round-robin arbiter that drains four class FIFOs into a single
//            downstream FIFO. It keeps a per-port word counter that can be
//            read back while the arbiter is idle.
//
// Ports
//   clk             : single clock, rising edge
//   reset           : synchronous, active-low reset (0 = reset)
//   init            : level request to (re)initialise counters and pointer
//   emptyP0..3      : empty flags of the four class FIFOs
//   dataP0..3       : class FIFO read data, valid one cycle after its pop
//   popP0..3        : read strobes to the class FIFOs (combinational)
//   almost_full_out : downstream pause flag (two entries reserved downstream)
//   pushOut         : write strobe to the downstream FIFO
//   dataOut         : forwarded word, qualified by pushOut, held otherwise
//   req / idx       : counter read request and port select
//   counterOut      : selected counter value (0 when counterValid = 0)
//   counterValid    : qualifies counterOut, one cycle after an idle request
//   idle            : high while the FSM sits in IDLE
//
// Revision : 1.0 - initial release
// ============================================================================
module tx_arbiter #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              emptyP0,
    input  logic              emptyP1,
    input  logic              emptyP2,
    input  logic              emptyP3,
    input  logic [DATA_W-1:0] dataP0,
    input  logic [DATA_W-1:0] dataP1,
    input  logic [DATA_W-1:0] dataP2,
    input  logic [DATA_W-1:0] dataP3,
    output logic              popP0,
    output logic              popP1,
    output logic              popP2,
    output logic              popP3,
    input  logic              almost_full_out,
    output logic              pushOut,
    output logic [DATA_W-1:0] dataOut,
    input  logic              req,
    input  logic [1:0]        idx,
    output logic [CNT_W-1:0]  counterOut,
    output logic              counterValid,
    output logic              idle
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_RESET  = 2'd0;
    localparam logic [1:0] S_INIT   = 2'd1;
    localparam logic [1:0] S_IDLE   = 2'd2;
    localparam logic [1:0] S_ACTIVE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    // Packed views of the per-port inputs/outputs
    logic [3:0]        w_empty;
    logic [DATA_W-1:0] w_data [4];
    logic [3:0]        w_pop;

    // Round-robin pointer: the port that was granted last
    logic [1:0]        r_ptr;

    // Pop selection
    logic              w_any_ready;
    logic              w_pop_any;
    logic [1:0]        w_pop_port;
    logic [1:0]        w_cand;

    // Counter clear: asserted for the init request itself and while in INIT
    logic              w_clear;

    // Stage 1: pop issued last cycle, FIFO data is on dataPk this cycle
    logic              r_s1_valid;
    logic              r_s1_cnt;
    logic [1:0]        r_s1_port;

    // Output stage: registered word presented to the downstream FIFO
    logic              r_push;
    logic              r_out_cnt;
    logic [1:0]        r_out_port;
    logic [DATA_W-1:0] r_dout;

    // Per-port word counters and the counter read port
    logic [CNT_W-1:0]  r_count [4];
    logic              r_cv;
    logic [CNT_W-1:0]  r_cout;
    logic              w_read_ok;

    assign w_empty     = {emptyP3, emptyP2, emptyP1, emptyP0};
    assign w_data[0]   = dataP0;
    assign w_data[1]   = dataP1;
    assign w_data[2]   = dataP2;
    assign w_data[3]   = dataP3;
    assign w_any_ready = ~&w_empty;
    assign w_clear     = init | (r_state == S_INIT);
    assign w_read_ok   = req & (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic. init overrides every state.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (init) begin
            w_next_state = S_INIT;
        end else begin
            case (r_state)
                S_RESET:  w_next_state = S_INIT;
                S_INIT:   w_next_state = S_IDLE;
                S_IDLE: begin
                    if (w_any_ready && !almost_full_out) begin
                        w_next_state = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (!w_any_ready || almost_full_out) begin
                        w_next_state = S_IDLE;
                    end
                end
                default:  w_next_state = S_RESET;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs. The pop is combinational on the current
    // flags so that a rising almost_full_out or init stops popping in the
    // very same cycle; the two words already in the pipeline fit into the
    // entries the downstream threshold keeps in reserve.
    // ------------------------------------------------------------------
    always_comb begin
        w_pop      = 4'b0000;
        w_pop_any  = 1'b0;
        w_pop_port = r_ptr;
        w_cand     = r_ptr;
        idle       = (r_state == S_IDLE);
        if ((r_state == S_ACTIVE) && reset && !init && !almost_full_out) begin
            // Search starts one past the last grant and ends on the last
            // grant itself, so a lone busy port is served every cycle.
            for (int i = 1; i <= 4; i++) begin
                w_cand = r_ptr + 2'(i);
                if (!w_pop_any && !w_empty[w_cand]) begin
                    w_pop_any  = 1'b1;
                    w_pop_port = w_cand;
                end
            end
            if (w_pop_any) begin
                w_pop[w_pop_port] = 1'b1;
            end
        end
    end

    assign popP0 = w_pop[0];
    assign popP1 = w_pop[1];
    assign popP2 = w_pop[2];
    assign popP3 = w_pop[3];

    // ------------------------------------------------------------------
    // Round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= 2'd0;
        end else if (w_clear) begin
            r_ptr <= 2'd0;
        end else if (w_pop_any) begin
            r_ptr <= w_pop_port;
        end
    end

    // ------------------------------------------------------------------
    // Data pipeline: pop in N, FIFO data in N+1, registered push in N+2.
    // The *_cnt flags travel with each word and are dropped by init, so
    // words already in flight when init arrives are still forwarded but
    // never counted against the freshly cleared counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_cnt   <= 1'b0;
            r_s1_port  <= 2'd0;
            r_push     <= 1'b0;
            r_out_cnt  <= 1'b0;
            r_out_port <= 2'd0;
            r_dout     <= '0;
        end else begin
            r_s1_valid <= w_pop_any;
            r_s1_cnt   <= w_pop_any;
            r_s1_port  <= w_pop_port;
            r_push     <= r_s1_valid;
            r_out_cnt  <= r_s1_valid & r_s1_cnt & ~init;
            if (r_s1_valid) begin
                r_dout     <= w_data[r_s1_port];
                r_out_port <= r_s1_port;
            end
        end
    end

    assign pushOut = r_push;
    assign dataOut = r_dout;

    // ------------------------------------------------------------------
    // Per-port counters: bumped at the end of each counted push cycle,
    // wrapping naturally at 2^CNT_W. Clearing wins over incrementing.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!reset) begin
                r_count[k] <= '0;
            end else if (w_clear) begin
                r_count[k] <= '0;
            end else if (r_push && r_out_cnt && (r_out_port == 2'(k))) begin
                r_count[k] <= r_count[k] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter read port: samples the counter value before any increment
    // landing on the same edge; an invalid read returns zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cv   <= 1'b0;
            r_cout <= '0;
        end else begin
            r_cv   <= w_read_ok;
            r_cout <= w_read_ok ? r_count[idx] : '0;
        end
    end

    assign counterValid = r_cv;
    assign counterOut   = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_arbiter
// Purpose  : Self-checking bench for tx_arbiter. Four behavioural class
//            FIFOs feed the DUT; a transaction-level model predicts pops,
//            pushes, counters and counter reads every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_arbiter;

    localparam int DW = 12;
    localparam int CW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          init;
    logic          almost_full_out;
    logic          req;
    logic [1:0]    idx;
    logic          emptyP0, emptyP1, emptyP2, emptyP3;
    logic [DW-1:0] dataP0, dataP1, dataP2, dataP3;
    logic          popP0, popP1, popP2, popP3;
    logic          pushOut;
    logic [DW-1:0] dataOut;
    logic [CW-1:0] counterOut;
    logic          counterValid;
    logic          idle;

    tx_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .emptyP0         (emptyP0),
        .emptyP1         (emptyP1),
        .emptyP2         (emptyP2),
        .emptyP3         (emptyP3),
        .dataP0          (dataP0),
        .dataP1          (dataP1),
        .dataP2          (dataP2),
        .dataP3          (dataP3),
        .popP0           (popP0),
        .popP1           (popP1),
        .popP2           (popP2),
        .popP3           (popP3),
        .almost_full_out (almost_full_out),
        .pushOut         (pushOut),
        .dataOut         (dataOut),
        .req             (req),
        .idx             (idx),
        .counterOut      (counterOut),
        .counterValid    (counterValid),
        .idle            (idle)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- class FIFO environment ----------------
    logic [DW-1:0] q0[$], q1[$], q2[$], q3[$];
    logic [DW-1:0] dreg [4];

    function automatic int fsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic fpush(int k, logic [DW-1:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            2:       q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    task automatic ftake(int k, output logic [DW-1:0] v);
        case (k)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            2:       v = q2.pop_front();
            default: v = q3.pop_front();
        endcase
    endtask

    task automatic fflush();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endtask

    function automatic bit all_empty();
        return (fsize(0) == 0) && (fsize(1) == 0) && (fsize(2) == 0) && (fsize(3) == 0);
    endfunction

    // ---------------- transaction-level reference model ----------------
    typedef enum int {M_RST, M_INIT, M_IDLE, M_ACT} mphase_t;
    typedef struct {
        int            due;     // cycle in which the push must appear
        logic [DW-1:0] data;
        int            port;
        bit            counts;  // still eligible to bump its counter
    } flight_t;

    mphase_t       m_phase;
    int            m_ptr;
    int            m_cnt [4];
    logic [DW-1:0] m_dout;
    bit            m_cv;
    int            m_co;
    int            cyc = 0;
    flight_t       pipe[$];
    int            pop_log[$];
    int            push_seen = 0;

    task automatic model_reset();
        m_phase = M_RST;
        m_ptr   = 0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        pipe.delete();
        m_dout  = '0;
        m_cv    = 1'b0;
        m_co    = 0;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive FIFO flags, check all outputs against the
    // model, advance the model and the FIFOs, end on the next falling edge.
    task automatic cycle();
        logic [3:0]    emp;
        logic [3:0]    pop_exp;
        logic [3:0]    pop_act;
        int            ep;
        int            c;
        bit            push_exp;
        logic [DW-1:0] dout_exp;
        logic [DW-1:0] word;
        int            pend_k;
        flight_t       f;

        for (int k = 0; k < 4; k++) emp[k] = (fsize(k) == 0);
        {emptyP3, emptyP2, emptyP1, emptyP0} = emp;
        dataP0 = dreg[0]; dataP1 = dreg[1]; dataP2 = dreg[2]; dataP3 = dreg[3];
        #1;

        ep = -1;
        if (m_phase == M_ACT && reset && !init && !almost_full_out) begin
            for (int j = 1; j <= 4; j++) begin
                c = (m_ptr + j) % 4;
                if (ep < 0 && !emp[c]) ep = c;
            end
        end
        pop_exp  = (ep >= 0) ? (4'b0001 << ep) : 4'b0000;
        push_exp = (pipe.size() > 0) && (pipe[0].due == cyc);
        dout_exp = push_exp ? pipe[0].data : m_dout;

        pop_act = {popP3, popP2, popP1, popP0};
        check("pop", 32'(pop_act), 32'(pop_exp));
        check("idle", 32'(idle), 32'(m_phase == M_IDLE));
        check("pushOut", 32'(pushOut), 32'(push_exp));
        check("dataOut", 32'(dataOut), 32'(dout_exp));
        check("counterValid", 32'(counterValid), 32'(m_cv));
        check("counterOut", 32'(counterOut), 32'(m_co));
        for (int j = 0; j < 4; j++) if (pop_act[j]) pop_log.push_back(j);
        if (pushOut === 1'b1) push_seen++;

        pend_k = -1;
        word   = '0;
        if (!reset) begin
            model_reset();
        end else begin
            m_cv = (m_phase == M_IDLE) && req;
            m_co = m_cv ? m_cnt[idx] : 0;
            if (push_exp) begin
                m_dout = pipe[0].data;
                if (pipe[0].counts) m_cnt[pipe[0].port] = (m_cnt[pipe[0].port] + 1) % (1 << CW);
                void'(pipe.pop_front());
            end
            if (init || m_phase == M_INIT) begin
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
                m_ptr = 0;
            end
            if (init) foreach (pipe[i]) pipe[i].counts = 1'b0;
            if (ep >= 0) begin
                m_ptr = ep;
                ftake(ep, word);
                pend_k   = ep;
                f.due    = cyc + 2;
                f.data   = word;
                f.port   = ep;
                f.counts = 1'b1;
                pipe.push_back(f);
            end
            if (init) m_phase = M_INIT;
            else begin
                case (m_phase)
                    M_RST:  m_phase = M_INIT;
                    M_INIT: m_phase = M_IDLE;
                    M_IDLE: if (emp != 4'hF && !almost_full_out) m_phase = M_ACT;
                    M_ACT:  if (emp == 4'hF || almost_full_out) m_phase = M_IDLE;
                    default: m_phase = M_RST;
                endcase
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
        if (pend_k >= 0) dreg[pend_k] = word;
    endtask

    task automatic drain(string tag, int limit);
        bit done;
        int i;
        done = 1'b0;
        i    = 0;
        while (!done && i < limit) begin
            if (m_phase == M_IDLE && pipe.size() == 0 && all_empty()) done = 1'b1;
            else begin
                cycle();
                i++;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic read_counter(int k, int exp);
        req = 1'b1;
        idx = 2'(k);
        cycle();
        req = 1'b0;
        check($sformatf("cnt_valid%0d", k), 32'(counterValid), 32'd1);
        check($sformatf("cnt_read%0d", k), 32'(counterOut), 32'(exp));
    endtask

    task automatic init_pulse();
        init = 1'b1;
        cycle();
        init = 1'b0;
        cycle();
        cycle();
    endtask

    int exp_order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int base;

    initial begin
        reset = 1'b0; init = 1'b0; almost_full_out = 1'b0; req = 1'b0; idx = 2'd0;
        {emptyP3, emptyP2, emptyP1, emptyP0} = 4'hF;
        dataP0 = '0; dataP1 = '0; dataP2 = '0; dataP3 = '0;
        for (int k = 0; k < 4; k++) dreg[k] = '0;
        model_reset();
        @(negedge clk);

        // Reset held low: everything quiet
        repeat (3) cycle();
        check("reset_idle", 32'(idle), 32'd0);
        check("reset_push", 32'(pushOut), 32'd0);
        reset = 1'b1;

        // Init with all FIFOs empty, then read counter 2
        init = 1'b1; cycle(); cycle(); init = 1'b0;
        repeat (3) cycle();
        check("idle_after_init", 32'(idle), 32'd1);
        read_counter(2, 0);

        // Only P2 busy with three 0x123 words
        for (int n = 0; n < 3; n++) fpush(2, 12'h123);
        base = push_seen;
        drain("drain_p2", 40);
        check("p2_pushes", 32'(push_seen - base), 32'd3);
        read_counter(2, 3);

        // All ports busy from pointer P0: strict rotation P1,P2,P3,P0,...
        init_pulse();
        for (int n = 0; n < 2; n++)
            for (int k = 0; k < 4; k++) fpush(k, DW'($urandom));
        pop_log.delete();
        base = push_seen;
        drain("drain_rr", 60);
        check("rr_pushes", 32'(push_seen - base), 32'd8);
        check("rr_pops", 32'(pop_log.size()), 32'd8);
        for (int n = 0; n < 8 && n < pop_log.size(); n++)
            check($sformatf("rr_order%0d", n), 32'(pop_log[n]), 32'(exp_order[n]));
        for (int k = 0; k < 4; k++) read_counter(k, 2);

        // Streaming with almost_full_out pauses
        init_pulse();
        for (int n = 0; n < 6; n++)
            for (int k = 0; k < 4; k++) fpush(k, DW'($urandom));
        for (int i = 0; i < 60; i++) begin
            almost_full_out = (i >= 6 && i < 10) || (i >= 20 && $urandom_range(0, 3) == 0);
            cycle();
        end
        almost_full_out = 1'b0;
        drain("drain_afull", 80);

        // Counter wrap: 33 pushes from P0
        init_pulse();
        for (int n = 0; n < 33; n++) fpush(0, DW'($urandom));
        drain("drain_wrap", 120);
        read_counter(0, 1);
        read_counter(1, 0);

        // Randomised traffic, pauses, reads and occasional init
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                int k;
                k = $urandom_range(0, 3);
                if (fsize(k) < 8) fpush(k, DW'($urandom));
            end
            almost_full_out = ($urandom_range(0, 4) == 0);
            req  = ($urandom_range(0, 2) == 0);
            idx  = 2'($urandom_range(0, 3));
            init = ($urandom_range(0, 99) == 0);
            cycle();
        end
        init = 1'b0; req = 1'b0; almost_full_out = 1'b0;
        drain("drain_rand", 200);

        // Reset in the middle of a stream
        init_pulse();
        for (int n = 0; n < 6; n++)
            for (int k = 0; k < 4; k++) fpush(k, DW'($urandom));
        repeat (6) cycle();
        reset = 1'b0;
        fflush();
        cycle();
        base = push_seen;
        repeat (2) cycle();
        reset = 1'b1;
        repeat (4) cycle();
        check("no_push_after_reset", 32'(push_seen - base), 32'd0);
        init_pulse();
        for (int k = 0; k < 4; k++) read_counter(k, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
